store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Write-side staging queue between the core's load/store path and the memory interface.
- Accepts core stores into a DEPTH-entry FIFO and drains them to memory one per cycle whenever the memory port is free.
- Loads pass straight through to memory; a load that hits a pending store gets the youngest matching data forwarded.
- Decouples store issue from memory-port contention; full-word stores only.

Parameters:
CORE, 0, core index, used in report output
DATA_WIDTH, 32, data word width
ADDRESS_BITS, 20, word address width
DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
core_read  input  1  load request this cycle
core_read_address  input  ADDRESS_BITS  load address
core_write  input  1  store request this cycle
core_write_address  input  ADDRESS_BITS  store address
core_write_data  input  DATA_WIDTH  store data
core_stall  output  1  request not accepted this cycle; core holds and retries
fwd_hit  output  1  load hit a pending store; use fwd_data instead of memory data
fwd_data  output  DATA_WIDTH  youngest matching pending store data
mem_read  output  1  read strobe to memory interface
mem_read_address  output  ADDRESS_BITS  read address to memory interface
mem_write  output  1  write strobe to memory interface
mem_write_address  output  ADDRESS_BITS  head-entry address
mem_write_data  output  DATA_WIDTH  head-entry data
report  input  1  print state on the next clock edge

Behaviour:
- Storage:
  - Circular FIFO with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
- Reset (asynchronous):
  - count, head and tail go to 0; all entry valid bits clear. Pending stores are discarded, including on reset mid-operation.
  - All outputs read 0 while reset is high.
- Drain decision (combinational, each cycle):
  - If count==DEPTH and core_write: drain, and drain takes priority over a core read.
  - Else if count>0 and !core_read: drain.
  - Else: no drain.
  - On drain, mem_write=1 and mem_write_address/mem_write_data come from the head entry; the head advances at the clock edge.
- Read pass-through:
  - mem_read = core_read & !core_stall; mem_read_address = core_read_address when mem_read, else 0.
  - Zero-cycle latency, purely combinational.
- Store accept:
  - Accepted when count<DEPTH, or when a drain occurs the same cycle.
  - Written at the tail on the clock edge; tail advances. The earliest drain of that entry is the next cycle.
- Stall:
  - core_stall=1 when count==DEPTH and core_write and core_read. The drain wins, the read waits one cycle and the store is accepted.
  - When the optional feature is off, core_stall is also asserted per that rule.
  - Otherwise core_stall=0.
- Count update per clock edge: count + accept − drain.
- Forwarding:
  - Compares core_read_address against all valid entries registered before this cycle.
  - A store enqueued in the same cycle is not visible.
  - If several entries match, the youngest (closest to tail) wins.
  - fwd_hit/fwd_data are combinational.
  - An entry draining this cycle is still eligible to match.
- Simultaneous core_read and core_write: both are handled; the read looks up only pre-existing entries.
- Report: on a clock edge with report=1, $display the cycle counter, count, head, tail and the state of every entry.

Optional Feature:
- Macro: STORE_BUFFER_FORWARD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - fwd_hit and fwd_data are tied to 0.
  - Any core_read whose address matches a pending entry asserts core_stall and forces a drain that cycle.
  - The read is retried until no entry matches, then issues to memory.

Decomposition:
- Shared package: DEPTH-derived pointer width, entry struct typedef {valid, address, data}, report format strings.
- One sub-module, store_buffer_match: parallel address compare plus youngest-first priority select over DEPTH entries, given head/tail. Outputs hit and data.

Test Plan:
- Reset then idle → count=0, mem_write=0, core_stall=0, fwd_hit=0.
- Store 0x00010 ← 0xDEADBEEF with no reads → mem_write next cycle with address 0x00010, data 0xDEADBEEF; count returns to 0.
- Stores to 0x00020 (0x11111111), then 0x00020 (0x22222222), while reads to 0x00100 suppress draining; then load 0x00020 → fwd_hit=1, fwd_data=0x22222222; load 0x00030 → fwd_hit=0.
- Fill DEPTH=4 entries under continuous reads, then a store with a read in the same cycle → core_stall=1, drain of the head entry, store accepted, count stays 4; the read issues the following cycle.
- Assert reset asynchronously with count=3 → count=0 immediately with no clock edge; no mem_write of the discarded entries.
- Without STORE_BUFFER_FORWARD_EN: pending 0x00040, load 0x00040 → core_stall=1 until the entry drains, then mem_read=1 with fwd_hit=0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: entry layout, pointer sizing and report text.
package store_buffer_pkg;

    localparam int SB_DATA_WIDTH   = 32;
    localparam int SB_ADDRESS_BITS = 20;

    typedef struct packed {
        logic                       valid;
        logic [SB_ADDRESS_BITS-1:0] address;
        logic [SB_DATA_WIDTH-1:0]   data;
    } entry_t;

    localparam int ENTRY_BITS = $bits(entry_t);

    localparam string REPORT_TAG = "[store_buffer]";

    // A single-entry buffer would still need a one-bit pointer to be a legal vector.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Parallel address compare over all buffer entries; the youngest matching entry supplies the data.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic [DEPTH*ENTRY_BITS-1:0]  entries,
    input  logic [PTR_WIDTH-1:0]         head,
    input  logic [SB_ADDRESS_BITS-1:0]   address,
    output logic                         hit,
    output logic [SB_DATA_WIDTH-1:0]     data
);

    entry_t [DEPTH-1:0]   slots;
    logic [PTR_WIDTH-1:0] idx;

    assign slots = entries;

    // Walk from oldest (head) to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_WIDTH'(k);
            if (slots[idx].valid && (slots[idx].address == address)) begin
                hit  = 1'b1;
                data = slots[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store staging FIFO between the core and memory, with load forwarding from pending stores.
// Optional feature macro: STORE_BUFFER_FORWARD_EN (undefined: matching loads stall until the store drains).
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = SB_DATA_WIDTH,
    parameter int ADDRESS_BITS = SB_ADDRESS_BITS,
    parameter int DEPTH        = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    core_read,
    input  logic [ADDRESS_BITS-1:0] core_read_address,
    input  logic                    core_write,
    input  logic [ADDRESS_BITS-1:0] core_write_address,
    input  logic [DATA_WIDTH-1:0]   core_write_data,
    output logic                    core_stall,
    output logic                    fwd_hit,
    output logic [DATA_WIDTH-1:0]   fwd_data,
    output logic                    mem_read,
    output logic [ADDRESS_BITS-1:0] mem_read_address,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    input  logic                    report
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    if (DATA_WIDTH != SB_DATA_WIDTH || ADDRESS_BITS != SB_ADDRESS_BITS) begin : g_width_check
        $error("store_buffer: DATA_WIDTH/ADDRESS_BITS must match store_buffer_pkg entry layout");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("store_buffer: DEPTH must be a power of two and at least 2");
    end

    entry_t [DEPTH-1:0] entries;
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;

    logic               full;
    logic               conflict;
    logic               drain;
    logic               accept;
    logic               stall;
    logic               match_hit;
    logic [DATA_WIDTH-1:0] match_data;

    store_buffer_match #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PW)
    ) u_match (
        .entries (entries),
        .head    (head),
        .address (core_read_address),
        .hit     (match_hit),
        .data    (match_data)
    );

    assign full = (count == CW'(DEPTH));

`ifdef STORE_BUFFER_FORWARD_EN
    assign conflict = 1'b0;
`else
    assign conflict = core_read & match_hit;
`endif

    // A full buffer with an incoming store must drain to make room, even at the cost of a read.
    always_comb begin
        drain = 1'b0;
        if (full && core_write) begin
            drain = 1'b1;
        end else if ((count != '0) && !core_read) begin
            drain = 1'b1;
        end else if (conflict) begin
            drain = 1'b1;
        end
    end

    assign stall  = (full & core_write & core_read) | conflict;
    assign accept = core_write & (~full | drain);

    assign core_stall        = ~reset & stall;
    assign mem_read          = ~reset & core_read & ~stall;
    assign mem_read_address  = mem_read ? core_read_address : '0;
    assign mem_write         = ~reset & drain;
    assign mem_write_address = mem_write ? entries[head].address : '0;
    assign mem_write_data    = mem_write ? entries[head].data : '0;

`ifdef STORE_BUFFER_FORWARD_EN
    assign fwd_hit  = ~reset & core_read & match_hit;
    assign fwd_data = fwd_hit ? match_data : '0;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // When full, head==tail: the enqueue is written after the drain so the new entry stays valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (drain) begin
                entries[head].valid <= 1'b0;
                head                <= head + PW'(1);
            end
            if (accept) begin
                entries[tail].valid   <= 1'b1;
                entries[tail].address <= core_write_address;
                entries[tail].data    <= core_write_data;
                tail                  <= tail + PW'(1);
            end
            count <= count + CW'(accept) - CW'(drain);
        end
    end

`ifndef SYNTHESIS
    logic [31:0] cycle;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (report) begin
            $display("%s core=%0d cycle=%0d count=%0d head=%0d tail=%0d lookup_hit=%0b lookup_data=0x%0h",
                     REPORT_TAG, CORE, cycle, count, head, tail, match_hit, match_data);
            for (int i = 0; i < DEPTH; i++) begin
                $display("%s core=%0d entry[%0d] valid=%0b address=0x%0h data=0x%0h",
                         REPORT_TAG, CORE, i, entries[i].valid, entries[i].address, entries[i].data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer; expectations follow STORE_BUFFER_FORWARD_EN when defined.
module tb_store_buffer;

    localparam int DW    = 32;
    localparam int AW    = 20;
    localparam int DEPTH = 4;

`ifdef STORE_BUFFER_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          core_read;
    logic [AW-1:0] core_read_address;
    logic          core_write;
    logic [AW-1:0] core_write_address;
    logic [DW-1:0] core_write_data;
    logic          core_stall;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          mem_read;
    logic [AW-1:0] mem_read_address;
    logic          mem_write;
    logic [AW-1:0] mem_write_address;
    logic [DW-1:0] mem_write_data;
    logic          report;

    always #5 clock = ~clock;

    store_buffer #(
        .CORE         (0),
        .DATA_WIDTH   (DW),
        .ADDRESS_BITS (AW),
        .DEPTH        (DEPTH)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .core_read          (core_read),
        .core_read_address  (core_read_address),
        .core_write         (core_write),
        .core_write_address (core_write_address),
        .core_write_data    (core_write_data),
        .core_stall         (core_stall),
        .fwd_hit            (fwd_hit),
        .fwd_data           (fwd_data),
        .mem_read           (mem_read),
        .mem_read_address   (mem_read_address),
        .mem_write          (mem_write),
        .mem_write_address  (mem_write_address),
        .mem_write_data     (mem_write_data),
        .report             (report)
    );

    typedef struct {
        logic          rd;
        logic [AW-1:0] ra;
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          stall;
        logic          fh;
        logic [DW-1:0] fd;
        logic          mr;
        logic [AW-1:0] mra;
        logic          mw;
        logic [AW-1:0] mwa;
        logic [DW-1:0] mwd;
        int            cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add(input logic rd, input logic [AW-1:0] ra,
                       input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic stall, input logic fh, input logic [DW-1:0] fd,
                       input logic mr, input logic [AW-1:0] mra,
                       input logic mw, input logic [AW-1:0] mwa, input logic [DW-1:0] mwd,
                       input int cnt);
        vec_t v;
        v.rd = rd;  v.ra = ra;  v.wr = wr;  v.wa = wa;  v.wd = wd;
        v.stall = stall;  v.fh = fh;  v.fd = fd;
        v.mr = mr;  v.mra = mra;  v.mw = mw;  v.mwa = mwa;  v.mwd = mwd;
        v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        core_read          = 1'b0;
        core_read_address  = '0;
        core_write         = 1'b0;
        core_write_address = '0;
        core_write_data    = '0;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        check($sformatf("v%0d core_stall", idx), 64'(core_stall), 64'(v.stall));
        check($sformatf("v%0d fwd_hit", idx), 64'(fwd_hit), 64'(v.fh));
        check($sformatf("v%0d fwd_data", idx), 64'(fwd_data), 64'(v.fd));
        check($sformatf("v%0d mem_read", idx), 64'(mem_read), 64'(v.mr));
        check($sformatf("v%0d mem_read_address", idx), 64'(mem_read_address), 64'(v.mra));
        check($sformatf("v%0d mem_write", idx), 64'(mem_write), 64'(v.mw));
        check($sformatf("v%0d mem_write_address", idx), 64'(mem_write_address), 64'(v.mwa));
        check($sformatf("v%0d mem_write_data", idx), 64'(mem_write_data), 64'(v.mwd));
    endtask

    // Drive on the falling edge, check outputs just before the rising edge, then check count after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clock);
        core_read          = v.rd;
        core_read_address  = v.ra;
        core_write         = v.wr;
        core_write_address = v.wa;
        core_write_data    = v.wd;
        #4;
        checkOutput(v, idx);
        @(posedge clock);
        #1;
        check($sformatf("v%0d count", idx), 64'(dut.count), 64'(v.cnt));
    endtask

    initial begin
        report = 1'b0;
        idle_inputs();

        // Outputs must read zero while reset is held, even with requests present.
        reset              = 1'b1;
        core_read          = 1'b1;
        core_read_address  = 20'h00055;
        core_write         = 1'b1;
        core_write_address = 20'h00066;
        core_write_data    = 32'h12345678;
        #2;
        check("reset mem_read", 64'(mem_read), 64'd0);
        check("reset mem_write", 64'(mem_write), 64'd0);
        check("reset core_stall", 64'(core_stall), 64'd0);
        check("reset fwd_hit", 64'(fwd_hit), 64'd0);
        check("reset count", 64'(dut.count), 64'd0);
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;

        // rd, ra, wr, wa, wd, stall, fh, fd, mr, mra, mw, mwa, mwd, cnt
        add(0, 0, 0, 0, 0,                           0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 20'h00010, 32'hDEADBEEF,        0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,                           0, 0, 0, 0, 0, 1, 20'h00010, 32'hDEADBEEF, 0);
        add(0, 0, 0, 0, 0,                           0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 20'h00100, 1, 20'h00020, 32'h11111111, 0, 0, 0, 1, 20'h00100, 0, 0, 0, 1);
        add(1, 20'h00100, 1, 20'h00020, 32'h22222222, 0, 0, 0, 1, 20'h00100, 0, 0, 0, 2);
        if (FWD) begin
            add(1, 20'h00020, 0, 0, 0, 0, 1, 32'h22222222, 1, 20'h00020, 0, 0, 0, 2);
            add(1, 20'h00030, 0, 0, 0, 0, 0, 0, 1, 20'h00030, 0, 0, 0, 2);
            add(0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 1, 20'h00020, 32'h11111111, 1);
            add(0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 1, 20'h00020, 32'h22222222, 0);
        end else begin
            add(1, 20'h00020, 0, 0, 0, 1, 0, 0, 0, 0, 1, 20'h00020, 32'h11111111, 1);
            add(1, 20'h00020, 0, 0, 0, 1, 0, 0, 0, 0, 1, 20'h00020, 32'h22222222, 0);
            add(1, 20'h00020, 0, 0, 0, 0, 0, 0, 1, 20'h00020, 0, 0, 0, 0);
            add(0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        add(1, 20'h00100, 1, 20'h00040, 32'h0000A000, 0, 0, 0, 1, 20'h00100, 0, 0, 0, 1);
        add(1, 20'h00100, 1, 20'h00041, 32'h0000A001, 0, 0, 0, 1, 20'h00100, 0, 0, 0, 2);
        add(1, 20'h00100, 1, 20'h00042, 32'h0000A002, 0, 0, 0, 1, 20'h00100, 0, 0, 0, 3);
        add(1, 20'h00100, 1, 20'h00043, 32'h0000A003, 0, 0, 0, 1, 20'h00100, 0, 0, 0, 4);
        add(1, 20'h00040, 1, 20'h00044, 32'h0000A004, 1, FWD, FWD ? 32'h0000A000 : 32'h0,
            0, 0, 1, 20'h00040, 32'h0000A000, 4);
        add(1, 20'h00040, 0, 0, 0, 0, 0, 0, 1, 20'h00040, 0, 0, 0, 4);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20'h00041, 32'h0000A001, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20'h00042, 32'h0000A002, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20'h00043, 32'h0000A003, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20'h00044, 32'h0000A004, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 20'h00100, 1, 20'h00060, 32'h0000B000, 0, 0, 0, 1, 20'h00100, 0, 0, 0, 1);
        add(1, 20'h00100, 1, 20'h00061, 32'h0000B001, 0, 0, 0, 1, 20'h00100, 0, 0, 0, 2);
        add(1, 20'h00100, 1, 20'h00062, 32'h0000B002, 0, 0, 0, 1, 20'h00100, 0, 0, 0, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset with three stores pending: state clears between clock edges.
        @(negedge clock);
        idle_inputs();
        core_read         = 1'b1;
        core_read_address = 20'h00100;
        #1;
        check("pre-reset mem_read", 64'(mem_read), 64'd1);
        core_read = 1'b0;
        #1;
        check("pre-reset mem_write", 64'(mem_write), 64'd1);
        check("pre-reset mem_write_address", 64'(mem_write_address), 64'h00060);
        core_read = 1'b1;
        reset     = 1'b1;
        #1;
        check("async reset count", 64'(dut.count), 64'd0);
        check("async reset head", 64'(dut.head), 64'd0);
        check("async reset tail", 64'(dut.tail), 64'd0);
        check("async reset mem_write", 64'(mem_write), 64'd0);
        check("async reset mem_read", 64'(mem_read), 64'd0);
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #4;
            check($sformatf("post-reset mem_write c%0d", c), 64'(mem_write), 64'd0);
            check($sformatf("post-reset count c%0d", c), 64'(dut.count), 64'd0);
            @(negedge clock);
        end

        report = 1'b1;
        @(negedge clock);
        report = 1'b0;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
